frame_sync_ctrl: RTL and testbench

Frame synchroniser and controller for the serial bit-sequence detection path. It hunts for a sync code in a serial bit stream and confirms it over consecutive frames before declaring lock. Once locked it flywheels on frame timing, deserialises the payload between sync codes, and drops lock after repeated sync misses. It sits between the serial receive front-end and the word-level consumer.

---
 rtl/frame_sync_if.sv | 26 ++
 rtl/frame_sync_ctrl.sv | 155 +++++++++++++++
 tb/tb_frame_sync_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sync_if.sv
// Frame synchroniser bus: serial bit input side plus word-level output side.
interface frame_sync_if #(
    parameter int PAYLOAD_W = 8,
    parameter int CNT_W     = 16
);
    logic                 din;
    logic                 din_valid;
    logic                 force_hunt;
    logic                 locked;
    logic [PAYLOAD_W-1:0] pay_data;
    logic                 pay_valid;
    logic                 sync_err;
    logic [CNT_W-1:0]     frame_cnt;

    // Front-end / consumer side
    modport master (
        output din, din_valid, force_hunt,
        input  locked, pay_data, pay_valid, sync_err, frame_cnt
    );

    // Synchroniser side
    modport slave (
        input  din, din_valid, force_hunt,
        output locked, pay_data, pay_valid, sync_err, frame_cnt
    );
endinterface

// File: rtl/frame_sync_ctrl.sv
// Frame synchroniser: hunts for a sync code, confirms it over consecutive
// frames, then flywheels on frame timing while deserialising the payload.
module frame_sync_ctrl #(
    parameter int                SYNC_W    = 4,
    parameter logic [SYNC_W-1:0] SYNC_CODE = 4'b1001,
    parameter int                PAYLOAD_W = 8,
    parameter int                CONFIRM   = 2,
    parameter int                MISS_MAX  = 3,
    parameter int                CNT_W     = 16
) (
    input  logic clk,
    input  logic rst,
    frame_sync_if.slave bus
);
    localparam int FRAME_LEN = SYNC_W + PAYLOAD_W;
    localparam int BW        = $clog2(FRAME_LEN);
    localparam int HW        = $clog2(CONFIRM + 1);
    localparam int MW        = $clog2(MISS_MAX + 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t               state, state_nx;
    logic [SYNC_W-1:0]    sr, sr_nx, window;
    logic [BW-1:0]        cnt, cnt_nx;
    logic [HW-1:0]        hits, hits_nx, hits_inc;
    logic [MW-1:0]        miss, miss_nx, miss_inc;
    logic [PAYLOAD_W-1:0] word, word_nx, pay_data, pay_data_nx;
    logic [CNT_W-1:0]     frame_cnt, frame_cnt_nx;
    logic                 locked, locked_nx;
    logic                 pay_valid, pay_valid_nx;
    logic                 sync_err, sync_err_nx;
    logic                 sync_hit, at_check, at_last_pay;

    // The window includes the incoming bit so a hit is known on the bit that completes the code
    assign window      = {bus.din, sr[SYNC_W-1:1]};
    assign sync_hit    = (window == SYNC_CODE) && bus.din_valid;
    assign at_check    = (cnt == BW'(FRAME_LEN - 1));
    assign at_last_pay = (cnt == BW'(PAYLOAD_W - 1));
    assign hits_inc    = hits + HW'(1);
    assign miss_inc    = miss + MW'(1);

    assign bus.locked    = locked;
    assign bus.pay_data  = pay_data;
    assign bus.pay_valid = pay_valid;
    assign bus.sync_err  = sync_err;
    assign bus.frame_cnt = frame_cnt;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            sr        <= '0;
            cnt       <= '0;
            hits      <= '0;
            miss      <= '0;
            word      <= '0;
            pay_data  <= '0;
            frame_cnt <= '0;
            locked    <= 1'b0;
            pay_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            state     <= state_nx;
            sr        <= sr_nx;
            cnt       <= cnt_nx;
            hits      <= hits_nx;
            miss      <= miss_nx;
            word      <= word_nx;
            pay_data  <= pay_data_nx;
            frame_cnt <= frame_cnt_nx;
            locked    <= locked_nx;
            pay_valid <= pay_valid_nx;
            sync_err  <= sync_err_nx;
        end
    end

    // Next-state and output decode; only valid bits (or force_hunt) move anything
    always_comb begin
        state_nx     = state;
        sr_nx        = sr;
        cnt_nx       = cnt;
        hits_nx      = hits;
        miss_nx      = miss;
        word_nx      = word;
        pay_data_nx  = pay_data;
        frame_cnt_nx = frame_cnt;
        pay_valid_nx = 1'b0;
        sync_err_nx  = 1'b0;

        if (bus.force_hunt) begin
            // sr deliberately keeps its contents: the bit on this cycle is dropped
            state_nx = HUNT;
            cnt_nx   = '0;
            hits_nx  = '0;
            miss_nx  = '0;
            word_nx  = '0;
        end else if (bus.din_valid) begin
            sr_nx = window;
            case (state)
                HUNT: begin
                    if (sync_hit) begin
                        cnt_nx   = '0;
                        hits_nx  = HW'(1);
                        state_nx = (CONFIRM == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (at_check) begin
                        cnt_nx = '0;
                        if (sync_hit) begin
                            hits_nx = hits_inc;
                            if (hits_inc == HW'(CONFIRM))
                                state_nx = LOCKED;
                        end else begin
                            state_nx = HUNT;
                            hits_nx  = '0;
                        end
                    end else begin
                        cnt_nx = cnt + BW'(1);
                    end
                end
                LOCKED: begin
                    for (int i = 0; i < PAYLOAD_W; i++)
                        if (cnt == BW'(i)) word_nx[i] = bus.din;
                    if (at_last_pay) begin
                        pay_data_nx  = word_nx;
                        pay_valid_nx = 1'b1;
                        frame_cnt_nx = frame_cnt + CNT_W'(1);
                    end
                    if (at_check) begin
                        cnt_nx = '0;
                        if (sync_hit) begin
                            miss_nx = '0;
                        end else begin
                            // Flywheel: keep frame timing, only count the miss
                            sync_err_nx = 1'b1;
                            if (miss_inc == MW'(MISS_MAX)) begin
                                state_nx = HUNT;
                                miss_nx  = '0;
                                hits_nx  = '0;
                            end else begin
                                miss_nx = miss_inc;
                            end
                        end
                    end else begin
                        cnt_nx = cnt + BW'(1);
                    end
                end
                default: state_nx = HUNT;
            endcase
        end

        locked_nx = (state_nx == LOCKED);
    end
endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Testbench for frame_sync_ctrl: randomized frames against a frame-position model.
module tb_frame_sync_ctrl;
    localparam logic [3:0] CODE = 4'b1001;
    localparam int FL = 12, PW = 8, CONF = 2, MMAX = 3;
    localparam int M_HUNT = 0, M_VER = 1, M_LOCK = 2;

    logic clk = 1'b0, rst = 1'b1, din = 1'b0, din_valid = 1'b0, force_hunt = 1'b0;
    always #5 clk = ~clk;

    frame_sync_if #(.PAYLOAD_W(8), .CNT_W(16)) bd ();
    frame_sync_if #(.PAYLOAD_W(8), .CNT_W(4))  bw ();
    assign bd.din = din;  assign bd.din_valid = din_valid;  assign bd.force_hunt = force_hunt;
    assign bw.din = din;  assign bw.din_valid = din_valid;  assign bw.force_hunt = force_hunt;

    frame_sync_ctrl dut (.clk(clk), .rst(rst), .bus(bd));
    frame_sync_ctrl #(.CNT_W(4)) dut_w (.clk(clk), .rst(rst), .bus(bw));

    // Reference model state: mode, position in frame, last four received bits
    int         m_mode, m_pos, m_hits, m_miss;
    bit         m_last [4];
    logic [7:0] m_word;
    logic       e_locked, e_pv, e_se;
    logic [7:0] e_pd;
    logic [15:0] e_fc;
    logic [7:0] exp_q[$], obs_q[$];
    int         obs_se, cyc_mis, gap_max;
    string      first_msg;
    int         tests_run, tests_failed;

    task automatic model_step(input logic b, input logic v, input logic fh, input logic r);
        bit hit;
        e_pv = 1'b0;
        e_se = 1'b0;
        if (r) begin
            m_mode = M_HUNT; m_pos = 0; m_hits = 0; m_miss = 0; m_word = '0;
            for (int i = 0; i < 4; i++) m_last[i] = 1'b0;
            e_pd = '0; e_fc = '0;
        end else if (fh) begin
            m_mode = M_HUNT; m_pos = 0; m_hits = 0; m_miss = 0; m_word = '0;
        end else if (v) begin
            for (int i = 0; i < 3; i++) m_last[i] = m_last[i+1];
            m_last[3] = b;
            hit = 1'b1;
            for (int i = 0; i < 4; i++) if (m_last[i] != CODE[i]) hit = 1'b0;
            if (m_mode == M_HUNT) begin
                if (hit) begin
                    m_hits = 1; m_pos = 0;
                    m_mode = (CONF == 1) ? M_LOCK : M_VER;
                end
            end else if (m_mode == M_VER) begin
                if (m_pos == FL - 1) begin
                    m_pos = 0;
                    if (hit) begin
                        m_hits++;
                        if (m_hits == CONF) m_mode = M_LOCK;
                    end else begin
                        m_mode = M_HUNT; m_hits = 0;
                    end
                end else m_pos++;
            end else begin
                if (m_pos < PW) m_word[m_pos] = b;
                if (m_pos == PW - 1) begin
                    e_pv = 1'b1; e_pd = m_word; e_fc = e_fc + 16'd1;
                    exp_q.push_back(m_word);
                end
                if (m_pos == FL - 1) begin
                    m_pos = 0;
                    if (hit) m_miss = 0;
                    else begin
                        e_se = 1'b1;
                        m_miss++;
                        if (m_miss == MMAX) begin
                            m_mode = M_HUNT; m_miss = 0; m_hits = 0;
                        end
                    end
                end else m_pos++;
            end
        end
        e_locked = (m_mode == M_LOCK);
    endtask

    // One clock: drive inputs at negedge, advance the model, sample after posedge
    task automatic step(input logic b, input logic v, input logic fh, input logic r);
        @(negedge clk);
        din = b; din_valid = v; force_hunt = fh; rst = r;
        model_step(b, v, fh, r);
        @(posedge clk);
        #1;
        if (bd.pay_valid) obs_q.push_back(bd.pay_data);
        if (bd.sync_err) obs_se++;
        if ({bd.locked, bd.pay_valid, bd.sync_err, bd.pay_data, bd.frame_cnt,
             bw.locked, bw.pay_valid, bw.sync_err, bw.pay_data, bw.frame_cnt} !==
            {e_locked, e_pv, e_se, e_pd, e_fc, e_locked, e_pv, e_se, e_pd, e_fc[3:0]}) begin
            if (cyc_mis == 0)
                first_msg = $sformatf("t=%0t got lk=%b pv=%b se=%b pd=%h fc=%h fcw=%h want lk=%b pv=%b se=%b pd=%h fc=%h",
                    $time, bd.locked, bd.pay_valid, bd.sync_err, bd.pay_data, bd.frame_cnt, bw.frame_cnt,
                    e_locked, e_pv, e_se, e_pd, e_fc);
            cyc_mis++;
        end
    endtask

    task automatic send_bit(input logic b);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (g) step(logic'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        step(b, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_sync(input bit good);
        for (int i = 0; i < 4; i++) send_bit(good ? CODE[i] : 1'b0);
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    task automatic start_test();
        cyc_mis = 0; obs_se = 0; first_msg = "";
        obs_q.delete(); exp_q.delete();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        start_test();
        tests_run++; if (bd.locked !== 1'b0) begin tests_failed++; $display("FAIL rst_locked: got %b want 0", bd.locked); end
        tests_run++; if (bd.pay_valid !== 1'b0 || bd.sync_err !== 1'b0) begin tests_failed++; $display("FAIL rst_pulses: got pv=%b se=%b want 0 0", bd.pay_valid, bd.sync_err); end
        tests_run++; if (bd.pay_data !== 8'h00) begin tests_failed++; $display("FAIL rst_pay_data: got %h want 00", bd.pay_data); end
        tests_run++; if (bd.frame_cnt !== 16'd0 || bw.frame_cnt !== 4'd0) begin tests_failed++; $display("FAIL rst_frame_cnt: got %0d/%0d want 0", bd.frame_cnt, bw.frame_cnt); end
    endtask

    task automatic test_clean_lock();
        start_test();
        send_sync(1'b1);
        tests_run++; if (bd.locked !== 1'b0) begin tests_failed++; $display("FAIL lock_early: got %b want 0", bd.locked); end
        send_word(8'hA5);
        tests_run++; if (obs_q.size() != 0) begin tests_failed++; $display("FAIL verify_payload: got %0d words want 0", obs_q.size()); end
        for (int i = 0; i < 3; i++) send_bit(CODE[i]);
        tests_run++; if (bd.locked !== 1'b0) begin tests_failed++; $display("FAIL lock_before_check: got %b want 0", bd.locked); end
        send_bit(CODE[3]);
        tests_run++; if (bd.locked !== 1'b1) begin tests_failed++; $display("FAIL lock_rise: got %b want 1", bd.locked); end
        send_word(8'h3C); send_sync(1'b1); send_word(8'hC3);
        tests_run++;
        if (obs_q.size() != 2 || obs_q[0] !== 8'h3C || obs_q[1] !== 8'hC3) begin
            tests_failed++; $display("FAIL clean_payload: got %0d words last=%h want 3C,C3", obs_q.size(), bd.pay_data);
        end
        tests_run++; if (bd.frame_cnt !== 16'd2) begin tests_failed++; $display("FAIL clean_frame_cnt: got %0d want 2", bd.frame_cnt); end
        tests_run++; if (cyc_mis != 0) begin tests_failed++; $display("FAIL clean_trace: %0d cycles differ, first %s", cyc_mis, first_msg); end
    endtask

    task automatic test_false_sync();
        logic [11:0] v;
        start_test();
        for (int t = 0; t < 3; t++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            send_sync(1'b1);
            do v = 12'($urandom_range(0, 4095)); while (v[11:8] == 4'b1001);
            for (int i = 0; i < 12; i++) send_bit(v[i]);
            tests_run++; if (bd.locked !== 1'b0) begin tests_failed++; $display("FAIL false_locked: got %b want 0 (v=%h)", bd.locked, v); end
        end
        tests_run++; if (obs_q.size() != 0) begin tests_failed++; $display("FAIL false_payload: got %0d words want 0", obs_q.size()); end
        tests_run++; if (cyc_mis != 0) begin tests_failed++; $display("FAIL false_trace: %0d cycles differ, first %s", cyc_mis, first_msg); end
    endtask

    task automatic test_flywheel();
        logic [7:0] w [6];
        bit good [6];
        start_test();
        send_sync(1'b1); send_word(8'($urandom)); send_sync(1'b1);
        tests_run++; if (bd.locked !== 1'b1) begin tests_failed++; $display("FAIL fly_lock: got %b want 1", bd.locked); end
        for (int i = 0; i < 6; i++) begin w[i] = 8'($urandom); good[i] = (i == 2); end
        for (int i = 0; i < 6; i++) begin
            send_word(w[i]);
            send_sync(good[i]);
            if (i == 1) begin
                tests_run++; if (obs_se != 2 || bd.locked !== 1'b1) begin tests_failed++; $display("FAIL fly_two_miss: got se=%0d lk=%b want 2 1", obs_se, bd.locked); end
            end
            if (i == 4) begin
                tests_run++; if (obs_se != 4 || bd.locked !== 1'b1) begin tests_failed++; $display("FAIL fly_miss_cleared: got se=%0d lk=%b want 4 1", obs_se, bd.locked); end
            end
        end
        tests_run++; if (obs_se != 5 || bd.locked !== 1'b0) begin tests_failed++; $display("FAIL fly_loss: got se=%0d lk=%b want 5 0", obs_se, bd.locked); end
        tests_run++;
        if (obs_q.size() != 6 || obs_q[0] !== w[0] || obs_q[3] !== w[3] || obs_q[5] !== w[5]) begin
            tests_failed++; $display("FAIL fly_payload: got %0d words want 6", obs_q.size());
        end
        tests_run++; if (cyc_mis != 0) begin tests_failed++; $display("FAIL fly_trace: %0d cycles differ, first %s", cyc_mis, first_msg); end
    endtask

    task automatic test_gaps_force();
        logic [7:0] w;
        start_test();
        gap_max = 5;
        send_sync(1'b1); send_word(8'hA5); send_sync(1'b1);
        tests_run++; if (bd.locked !== 1'b1) begin tests_failed++; $display("FAIL gap_lock: got %b want 1", bd.locked); end
        send_word(8'h3C); send_sync(1'b1); send_word(8'hC3);
        tests_run++;
        if (obs_q.size() != 2 || obs_q[0] !== 8'h3C || obs_q[1] !== 8'hC3) begin
            tests_failed++; $display("FAIL gap_payload: got %0d words last=%h want 3C,C3", obs_q.size(), bd.pay_data);
        end
        send_sync(1'b1);
        w = 8'($urandom);
        for (int i = 0; i < 4; i++) send_bit(w[i]);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        tests_run++; if (bd.locked !== 1'b0) begin tests_failed++; $display("FAIL force_unlock: got %b want 0", bd.locked); end
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        tests_run++;
        if (obs_q.size() != 2 || bd.frame_cnt !== 16'd2 || bd.pay_data !== 8'hC3) begin
            tests_failed++; $display("FAIL force_hold: got words=%0d fc=%0d pd=%h want 2 2 C3", obs_q.size(), bd.frame_cnt, bd.pay_data);
        end
        gap_max = 0;
        tests_run++; if (cyc_mis != 0) begin tests_failed++; $display("FAIL gap_trace: %0d cycles differ, first %s", cyc_mis, first_msg); end
    endtask

    task automatic test_reset_mid();
        start_test();
        send_sync(1'b1); send_word(8'h5A); send_sync(1'b1);
        send_word(8'h12); send_sync(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        tests_run++;
        if (bd.locked !== 1'b0 || bd.pay_valid !== 1'b0 || bd.sync_err !== 1'b0 || bd.pay_data !== 8'h00 || bd.frame_cnt !== 16'd0) begin
            tests_failed++; $display("FAIL mid_reset: got lk=%b pv=%b se=%b pd=%h fc=%0d want all 0", bd.locked, bd.pay_valid, bd.sync_err, bd.pay_data, bd.frame_cnt);
        end
        obs_q.delete();
        send_sync(1'b1); send_word(8'hA5); send_sync(1'b1);
        send_word(8'h3C); send_sync(1'b1); send_word(8'hC3);
        tests_run++;
        if (obs_q.size() != 2 || obs_q[1] !== 8'hC3 || bd.frame_cnt !== 16'd2) begin
            tests_failed++; $display("FAIL mid_reacquire: got words=%0d fc=%0d want 2 2", obs_q.size(), bd.frame_cnt);
        end
        tests_run++; if (cyc_mis != 0) begin tests_failed++; $display("FAIL mid_trace: %0d cycles differ, first %s", cyc_mis, first_msg); end
    endtask

    task automatic test_wrap();
        int bad;
        bad = 0;
        start_test();
        send_sync(1'b1); send_word(8'($urandom)); send_sync(1'b1);
        for (int k = 1; k <= 17; k++) begin
            send_word(8'($urandom));
            tests_run++;
            if (bw.pay_valid !== 1'b1 || bw.frame_cnt !== 4'(k) || bd.frame_cnt !== 16'(k)) begin
                tests_failed++; bad++;
                $display("FAIL wrap_k%0d: got pv=%b fc4=%0d fc16=%0d want 1 %0d %0d", k, bw.pay_valid, bw.frame_cnt, bd.frame_cnt, k % 16, k);
            end
            send_sync(1'b1);
        end
        tests_run++; if (cyc_mis != 0) begin tests_failed++; $display("FAIL wrap_trace: %0d cycles differ, first %s", cyc_mis, first_msg); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; gap_max = 0;
        test_reset();
        test_clean_lock();
        test_false_sync();
        test_flywheel();
        test_gaps_force();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
